// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, flag bit positions and
// the control FSM state type.
//
// Contents:
//   Op*      4-bit opcodes carried in FunSel[3:0]; FunSel[4] selects full width
//   Flag*    bit positions of Z, C, N, O inside the 4-bit flag word
//   state_e  control FSM states
//   is_shift true for the iterative shift/rotate opcodes
package alu_pkg;

    localparam logic [3:0] OpPassA = 4'd0;
    localparam logic [3:0] OpPassB = 4'd1;
    localparam logic [3:0] OpNotA  = 4'd2;
    localparam logic [3:0] OpNotB  = 4'd3;
    localparam logic [3:0] OpAdd   = 4'd4;
    localparam logic [3:0] OpAdc   = 4'd5;
    localparam logic [3:0] OpSub   = 4'd6;
    localparam logic [3:0] OpAnd   = 4'd7;
    localparam logic [3:0] OpOr    = 4'd8;
    localparam logic [3:0] OpXor   = 4'd9;
    localparam logic [3:0] OpNand  = 4'd10;
    localparam logic [3:0] OpLsl   = 4'd11;
    localparam logic [3:0] OpLsr   = 4'd12;
    localparam logic [3:0] OpAsr   = 4'd13;
    localparam logic [3:0] OpCsl   = 4'd14;
    localparam logic [3:0] OpCsr   = 4'd15;

    localparam int unsigned FlagZ = 3;
    localparam int unsigned FlagC = 2;
    localparam int unsigned FlagN = 1;
    localparam int unsigned FlagO = 0;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        HOLD
    } state_e;

    // Shift/rotate opcodes occupy the top of the opcode space.
    function automatic logic is_shift(input logic [3:0] op);
        return op >= OpLsl;
    endfunction

endpackage

// File: rtl/alu_step_core.sv
// Combinational datapath of the sequential ALU. Produces, at width N (HALF or
// WIDTH), the single-cycle result and flags of any opcode, plus one step of a
// shift/rotate on operand a.
//
// Ports:
//   a, b       operands (upper half ignored in half mode)
//   full       1 = full width, 0 = half width
//   op         opcode
//   c_in, o_in current C and O flags (held values, ADC carry-in)
//   step_cin   running carry for the rotate-through-carry step
//   res        single-cycle result, zero above N
//   res_flags  {Z,C,N,O} of res
//   step_val   a after one shift/rotate step, zero above N
//   step_cout  bit shifted out by that step
module alu_step_core #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             full,
    input  logic [3:0]       op,
    input  logic             c_in,
    input  logic             o_in,
    input  logic             step_cin,
    output logic [WIDTH-1:0] res,
    output logic [3:0]       res_flags,
    output logic [WIDTH-1:0] step_val,
    output logic             step_cout
);
    import alu_pkg::*;

    localparam int unsigned HALF = WIDTH / 2;

    function automatic logic top_bit(input logic [WIDTH-1:0] v, input logic f);
        return f ? v[WIDTH-1] : v[HALF-1];
    endfunction

    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] a_m;
    logic [WIDTH-1:0] b_m;
    logic [WIDTH-1:0] b_add;
    logic             add_cin;
    logic [WIDTH:0]   sum_f;
    logic [HALF:0]    sum_h;
    logic [WIDTH-1:0] add_res;
    logic             add_cout;
    logic             add_ovf;
    logic             carry;
    logic             ovf;

    assign mask = full ? {WIDTH{1'b1}} : {{HALF{1'b0}}, {HALF{1'b1}}};
    assign a_m  = a & mask;
    assign b_m  = b & mask;

    // SUB is A + ~B + 1, sharing the adder with ADD/ADC.
    assign b_add   = (op == OpSub) ? (~b_m & mask) : b_m;
    assign add_cin = (op == OpSub) ? 1'b1 : ((op == OpAdc) ? c_in : 1'b0);

    assign sum_f = {1'b0, a_m} + {1'b0, b_add} + {{WIDTH{1'b0}}, add_cin};
    assign sum_h = {1'b0, a_m[HALF-1:0]} + {1'b0, b_add[HALF-1:0]} + {{HALF{1'b0}}, add_cin};

    assign add_res  = full ? sum_f[WIDTH-1:0] : {{HALF{1'b0}}, sum_h[HALF-1:0]};
    assign add_cout = full ? sum_f[WIDTH] : sum_h[HALF];
    // Overflow: operands agree in sign but the result does not.
    assign add_ovf  = (top_bit(a_m, full) == top_bit(b_add, full)) &&
                      (top_bit(add_res, full) != top_bit(a_m, full));

    always_comb begin
        res   = a_m;
        carry = c_in;
        ovf   = o_in;
        unique case (op)
            OpPassA: res = a_m;
            OpPassB: res = b_m;
            OpNotA:  res = ~a_m & mask;
            OpNotB:  res = ~b_m & mask;
            OpAdd, OpAdc, OpSub: begin
                res   = add_res;
                carry = add_cout;
                ovf   = add_ovf;
            end
            OpAnd:   res = a_m & b_m;
            OpOr:    res = a_m | b_m;
            OpXor:   res = a_m ^ b_m;
            OpNand:  res = ~(a_m & b_m) & mask;
            // Shift with a zero count passes A through, C and O hold.
            default: res = a_m;
        endcase
        res_flags        = '0;
        res_flags[FlagZ] = (res == '0);
        res_flags[FlagC] = carry;
        res_flags[FlagN] = top_bit(res, full);
        res_flags[FlagO] = ovf;
    end

    always_comb begin
        step_val  = a_m;
        step_cout = step_cin;
        case (op)
            OpLsl: begin
                step_val  = (a_m << 1) & mask;
                step_cout = top_bit(a_m, full);
            end
            OpLsr: begin
                step_val  = a_m >> 1;
                step_cout = a_m[0];
            end
            OpAsr: begin
                step_val  = full ? {a_m[WIDTH-1], a_m[WIDTH-1:1]}
                                 : {{HALF{1'b0}}, a_m[HALF-1], a_m[HALF-1:1]};
                step_cout = a_m[0];
            end
            OpCsl: begin
                step_val  = ((a_m << 1) | {{(WIDTH-1){1'b0}}, step_cin}) & mask;
                step_cout = top_bit(a_m, full);
            end
            OpCsr: begin
                step_val  = full ? {step_cin, a_m[WIDTH-1:1]}
                                 : {{HALF{1'b0}}, step_cin, a_m[HALF-1:1]};
                step_cout = a_m[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked multi-cycle ALU. Single-cycle ops complete one cycle after the
// accept edge; shifts/rotates iterate one bit per cycle. Owns the {Z,C,N,O}
// flag register, which is written only when an op with WF = 1 completes.
//
// Ports:
//   Clock, Reset       rising-edge clock, synchronous active-low reset
//   InValid, InReady   request handshake
//   A, B, FunSel, WF   operands, {full, opcode}, write-flags enable
//   OutValid, OutReady result handshake
//   ALUOut, FlagsOut   registered result and architectural flags
module seq_alu #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       FunSel,
    input  logic             WF,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] ALUOut,
    output logic [3:0]       FlagsOut
);
    import alu_pkg::*;

    localparam int unsigned HALF = WIDTH / 2;
    localparam int unsigned CW   = $clog2(WIDTH);
    localparam int unsigned HCW  = $clog2(HALF);
    localparam logic [CW-1:0] HalfCntMask = CW'((1 << HCW) - 1);

    if ((WIDTH % 2) != 0 || WIDTH < 8) begin : g_bad_width
        $error("seq_alu: WIDTH must be even and >= 8");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [3:0]       flags_q, flags_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic             full_q, full_d;
    logic             wf_q, wf_d;
    logic             carry_q, carry_d;

    logic             accept;
    logic             in_exec;
    logic [CW-1:0]    cnt_in;
    logic [WIDTH-1:0] core_a;
    logic [3:0]       core_op;
    logic             core_full;
    logic [WIDTH-1:0] core_res;
    logic [3:0]       core_flags;
    logic [WIDTH-1:0] step_val;
    logic             step_cout;
    logic             step_n;

    assign InReady  = Reset & ((state_q == IDLE) | ((state_q == HOLD) & OutReady));
    assign accept   = InValid & InReady;
    assign OutValid = (state_q == HOLD);
    assign ALUOut   = res_q;
    assign FlagsOut = flags_q;

    assign cnt_in = B[CW-1:0] & (FunSel[4] ? {CW{1'b1}} : HalfCntMask);

    // The core sees the live request when idle/holding and the working
    // register while iterating.
    assign in_exec   = (state_q == EXEC);
    assign core_a    = in_exec ? work_q : A;
    assign core_op   = in_exec ? op_q : FunSel[3:0];
    assign core_full = in_exec ? full_q : FunSel[4];
    assign step_n    = full_q ? step_val[WIDTH-1] : step_val[HALF-1];

    alu_step_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a        (core_a),
        .b        (B),
        .full     (core_full),
        .op       (core_op),
        .c_in     (flags_q[FlagC]),
        .o_in     (flags_q[FlagO]),
        .step_cin (carry_q),
        .res      (core_res),
        .res_flags(core_flags),
        .step_val (step_val),
        .step_cout(step_cout)
    );

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        res_d   = res_q;
        flags_d = flags_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        full_d  = full_q;
        wf_d    = wf_q;
        carry_d = carry_q;
        unique case (state_q)
            IDLE, HOLD: begin
                if (accept) begin
                    op_d   = FunSel[3:0];
                    full_d = FunSel[4];
                    wf_d   = WF;
                    if (is_shift(FunSel[3:0]) && cnt_in != '0) begin
                        // core_res is the masked A for shift opcodes.
                        work_d  = core_res;
                        carry_d = flags_q[FlagC];
                        cnt_d   = cnt_in;
                        state_d = EXEC;
                    end else begin
                        res_d = core_res;
                        if (WF) begin
                            flags_d = core_flags;
                        end
                        state_d = HOLD;
                    end
                end else if (state_q == HOLD && OutReady) begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                work_d  = step_val;
                carry_d = step_cout;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    res_d   = step_val;
                    state_d = HOLD;
                    if (wf_q) begin
                        flags_d[FlagZ] = (step_val == '0);
                        flags_d[FlagC] = step_cout;
                        flags_d[FlagN] = step_n;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= IDLE;
            work_q  <= '0;
            res_q   <= '0;
            flags_q <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            full_q  <= 1'b0;
            wf_q    <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            full_q  <= full_d;
            wf_q    <= wf_d;
            carry_q <= carry_d;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH = 16): directed sequence with literal
// expectations, then randomized traffic checked against a transaction model.
module tb_seq_alu;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic [4:0]  FunSel = '0;
    logic        WF = 1'b0;
    logic        OutValid;
    logic        OutReady = 1'b0;
    logic [15:0] ALUOut;
    logic [3:0]  FlagsOut;

    always #5 Clock = ~Clock;

    seq_alu #(
        .WIDTH(16)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .InValid (InValid),
        .InReady (InReady),
        .A       (A),
        .B       (B),
        .FunSel  (FunSel),
        .WF      (WF),
        .OutValid(OutValid),
        .OutReady(OutReady),
        .ALUOut  (ALUOut),
        .FlagsOut(FlagsOut)
    );

    int checks = 0;
    int errors = 0;

    // Transaction model: 0 = free, 1 = computing, 2 = result presented.
    int          m_phase = 0;
    int          m_remain = 0;
    logic [15:0] m_res = '0;
    logic [3:0]  m_flags = '0;
    logic        m_res_known = 1'b1;
    logic [15:0] p_res = '0;
    logic [3:0]  p_flags = '0;
    logic        p_wf = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Result, flags and extra cycles of one op, from the arithmetic definitions.
    function automatic void model_op(input logic [15:0] a, input logic [15:0] b,
                                     input logic [4:0] fs, input logic [3:0] fl,
                                     output logic [15:0] r, output logic [3:0] fo,
                                     output int lat);
        longint n, mask, half, av, bv, sa, sb, s, x, y, m1, rr, cnt, cin, sv;
        logic   c, o;
        n    = fs[4] ? 16 : 8;
        mask = (longint'(1) << n) - 1;
        half = (mask + 1) / 2;
        av   = longint'(a) & mask;
        bv   = longint'(b) & mask;
        sa   = (av >= half) ? av - (mask + 1) : av;
        sb   = (bv >= half) ? bv - (mask + 1) : bv;
        c    = fl[2];
        o    = fl[0];
        cnt  = bv & (n - 1);
        lat  = 0;
        rr   = av;
        case (fs[3:0])
            4'd0: rr = av;
            4'd1: rr = bv;
            4'd2: rr = (~av) & mask;
            4'd3: rr = (~bv) & mask;
            4'd4, 4'd5: begin
                cin = (fs[3:0] == 4'd5 && fl[2]) ? 1 : 0;
                s   = av + bv + cin;
                rr  = s & mask;
                c   = ((s >> n) & 1) != 0;
                sv  = sa + sb + cin;
                o   = (sv > half - 1) || (sv < -half);
            end
            4'd6: begin
                s  = av + ((~bv) & mask) + 1;
                rr = s & mask;
                c  = ((s >> n) & 1) != 0;
                sv = sa - sb;
                o  = (sv > half - 1) || (sv < -half);
            end
            4'd7:  rr = av & bv;
            4'd8:  rr = av | bv;
            4'd9:  rr = av ^ bv;
            4'd10: rr = (~(av & bv)) & mask;
            default: begin
                if (cnt != 0) begin
                    lat = int'(cnt);
                    x   = ((c ? longint'(1) : longint'(0)) << n) | av;
                    m1  = (mask << 1) | 1;
                    case (fs[3:0])
                        4'd11: begin
                            rr = (av << cnt) & mask;
                            c  = ((av >> (n - cnt)) & 1) != 0;
                        end
                        4'd12: begin
                            rr = av >> cnt;
                            c  = ((av >> (cnt - 1)) & 1) != 0;
                        end
                        4'd13: begin
                            rr = (sa >>> cnt) & mask;
                            c  = ((av >> (cnt - 1)) & 1) != 0;
                        end
                        4'd14: begin
                            y  = ((x << cnt) | (x >> (n + 1 - cnt))) & m1;
                            rr = y & mask;
                            c  = ((y >> n) & 1) != 0;
                        end
                        default: begin
                            y  = ((x >> cnt) | (x << (n + 1 - cnt))) & m1;
                            rr = y & mask;
                            c  = ((y >> n) & 1) != 0;
                        end
                    endcase
                end
            end
        endcase
        r  = rr[15:0];
        fo = {rr == 0, c, ((rr >> (n - 1)) & 1) != 0, o};
    endfunction

    // One clock cycle: drive at the falling edge, check ready before the
    // rising edge, advance the model on it, check outputs at the next fall.
    task automatic step(input logic rst, input logic iv, input logic [15:0] a,
                        input logic [15:0] b, input logic [4:0] fs, input logic wf,
                        input logic orr);
        logic [15:0] r;
        logic [3:0]  f;
        int          lat;
        logic        exp_ready;
        logic        acc;
        r   = '0;
        f   = '0;
        lat = 0;
        Reset    = rst;
        InValid  = iv;
        A        = a;
        B        = b;
        FunSel   = fs;
        WF       = wf;
        OutReady = orr;
        #1;
        exp_ready = rst && (m_phase == 0 || (m_phase == 2 && orr));
        chk("in_ready", InReady, exp_ready);
        acc = iv && exp_ready;
        if (acc) model_op(a, b, fs, m_flags, r, f, lat);
        @(posedge Clock);
        if (!rst) begin
            m_phase     = 0;
            m_res       = '0;
            m_flags     = '0;
            m_res_known = 1'b1;
        end else if (acc) begin
            m_res_known = 1'b0;
            if (lat == 0) begin
                m_phase = 2;
                m_res   = r;
                if (wf) m_flags = f;
            end else begin
                m_phase  = 1;
                m_remain = lat;
                p_res    = r;
                p_flags  = f;
                p_wf     = wf;
            end
        end else if (m_phase == 1) begin
            m_remain--;
            if (m_remain == 0) begin
                m_phase = 2;
                m_res   = p_res;
                if (p_wf) m_flags = p_flags;
            end
        end else if (m_phase == 2 && orr) begin
            m_phase = 0;
        end
        @(negedge Clock);
        chk("out_valid", OutValid, m_phase == 2);
        chk("flags_out", FlagsOut, m_flags);
        if (m_phase == 2 || m_res_known) chk("alu_out", ALUOut, m_res);
    endtask

    task automatic idle(input logic orr);
        step(1'b1, 1'b0, 16'h0, 16'h0, 5'b0, 1'b0, orr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step(1'b0, 1'b0, 16'h0, 16'h0, 5'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0, 16'h0, 5'b0, 1'b0, 1'b0);
        chk("rst_valid", OutValid, 1'b0);
        chk("rst_out", ALUOut, 16'h0000);
        chk("rst_flags", FlagsOut, 4'b0000);

        // Full ADD overflowing into the sign bit.
        step(1'b1, 1'b1, 16'h7FFF, 16'h0001, 5'b10100, 1'b1, 1'b1);
        chk("add_valid", OutValid, 1'b1);
        chk("add_out", ALUOut, 16'h8000);
        chk("add_flags", FlagsOut, 4'b0011);

        // Back-to-back half ADD then ADC using the fresh carry.
        step(1'b1, 1'b1, 16'h00FF, 16'h0001, 5'b00100, 1'b1, 1'b1);
        chk("hadd_out", ALUOut, 16'h0000);
        chk("hadd_flags", FlagsOut, 4'b1100);
        step(1'b1, 1'b1, 16'h0001, 16'h0001, 5'b00101, 1'b1, 1'b1);
        chk("adc_out", ALUOut, 16'h0003);
        chk("adc_c", FlagsOut[2], 1'b0);

        // Full LSL by 3: valid four cycles after the accept edge.
        step(1'b1, 1'b1, 16'hA001, 16'h0003, 5'b11011, 1'b1, 1'b1);
        chk("lsl_busy0", OutValid, 1'b0);
        idle(1'b1);
        idle(1'b1);
        chk("lsl_busy2", OutValid, 1'b0);
        idle(1'b1);
        chk("lsl_valid", OutValid, 1'b1);
        chk("lsl_out", ALUOut, 16'h0008);
        chk("lsl_flags", FlagsOut, 4'b0100);

        // Stall a result for five cycles with a request pending.
        idle(1'b1);
        step(1'b1, 1'b1, 16'h00F0, 16'h000F, 5'b11001, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 16'h0005, 16'h0003, 5'b10110, 1'b0, 1'b0);
            chk("stall_out", ALUOut, 16'h00FF);
            chk("stall_flags", FlagsOut, 4'b0100);
            chk("stall_ready", InReady, 1'b0);
        end
        // SUB with WF = 0 leaves flags alone.
        step(1'b1, 1'b1, 16'h0005, 16'h0003, 5'b10110, 1'b0, 1'b1);
        chk("nowf_out", ALUOut, 16'h0002);
        chk("nowf_flags", FlagsOut, 4'b0100);

        // CSR with zero count passes A and keeps C.
        step(1'b1, 1'b1, 16'h1234, 16'h0010, 5'b11111, 1'b1, 1'b1);
        chk("csr0_out", ALUOut, 16'h1234);
        chk("csr0_flags", FlagsOut, 4'b0100);

        // LSR by 15 aborted by reset on its third iteration cycle.
        step(1'b1, 1'b1, 16'hFFFF, 16'h000F, 5'b11100, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);
        step(1'b0, 1'b0, 16'h0, 16'h0, 5'b0, 1'b0, 1'b1);
        chk("abort_valid", OutValid, 1'b0);
        chk("abort_out", ALUOut, 16'h0000);
        chk("abort_flags", FlagsOut, 4'b0000);
        idle(1'b1);

        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 299) != 0, ($urandom % 4) != 0,
                 16'($urandom), 16'($urandom), 5'($urandom), 1'($urandom),
                 ($urandom % 4) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked successor to the codebase's single-cycle ALU. Executes the 32 FunSel operations in either half-width or full-width mode, on a WIDTH-bit datapath. Shift and rotate operations become multi-bit: they iterate one bit per cycle under a small FSM. Sits between the register file / operand muxes and the writeback path, and owns the architectural Z C N O flag register.

## Interface
- WIDTH, 16, datapath width; must be even and >= 8. HALF = WIDTH/2.
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-low reset
- InValid  in  1  operation request valid
- InReady  out  1  block can accept a request this cycle
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B; for shifts/rotates, B supplies the shift count
- FunSel  in  5  operation; bit 4 = 1 selects full width, bit 4 = 0 selects half width; bits 3:0 give the opcode
- WF  in  1  write-flags enable, captured with the request
- OutValid  out  1  result valid
- OutReady  in  1  consumer accepts the result
- ALUOut  out  WIDTH  result; bits above HALF are 0 in half mode
- FlagsOut  out  4  {Z,C,N,O} at bits [3:0]

## Operation
- Opcodes 0..15: A, B, ~A, ~B, ADD, ADC, SUB, AND, OR, XOR, NAND, LSL, LSR, ASR, CSL, CSR.
- Width N is HALF in half mode and WIDTH in full mode. Operands are A[N-1:0] and B[N-1:0]; flags are taken at bit N-1.
- Z = (result == 0). N = result[N-1].
- ADD/ADC:
  - C = carry out of bit N-1.
  - O = signed overflow.
  - ADC adds FlagsOut.C as it stands when the request is accepted.
- SUB: computes A + ~B + 1. C = carry out (1 means no borrow). O = signed overflow.
- Pass, NOT and logic ops: update Z and N only; C and O hold.
- Shift count cnt = B[log2(N)-1:0].
  - LSL/LSR shift zeros in.
  - ASR replicates bit N-1.
  - CSL/CSR rotate through carry: CSL is {r[N-2:0],C} and C gets r[N-1]; CSR is mirrored.
  - After each step, C = the bit shifted out. O holds.
  - If cnt = 0: result = A, C holds, Z and N update.
- FSM states:
  - IDLE: InReady = 1.
  - EXEC: performs one shift step per cycle while the count is nonzero.
  - HOLD: OutValid = 1.
- Transitions:
  - On accept, non-shift ops and cnt = 0 go to HOLD.
  - On accept, shifts with cnt > 0 go to EXEC.
  - EXEC goes to HOLD after its last step.
  - HOLD with OutReady goes to IDLE, or accepts a new request in the same cycle.
- InReady = (state == IDLE) | (state == HOLD & OutReady). InReady is 0 while Reset is low.
- Flags commit on the HOLD entry edge, only if the captured WF = 1. A back-to-back ADC/CSL therefore sees the previous op's carry.

## Timing
- Reset values: ALUOut = 0, FlagsOut = 0, OutValid = 0, state = IDLE.
- Latency from accept edge to OutValid:
  - 1 cycle for non-shift ops and cnt = 0.
  - 1 + cnt cycles for shifts with cnt > 0.
- Throughput for single-cycle ops is 1 per cycle when OutReady is held high.
- While OutValid = 1 and OutReady = 0: ALUOut, FlagsOut and OutValid are stable, and InReady = 0.
- Inputs are sampled only on the accept edge; A, B, FunSel and WF may change freely afterwards.
- Reset low mid-EXEC or mid-HOLD aborts the operation: no flag update, and outputs return to reset values on the next edge.
- Maximum shift count is N-1; rotations do not wrap beyond that.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams;
  - flag bit indices Z = 3, C = 2, N = 1, O = 0;
  - FSM state enum {IDLE, EXEC, HOLD}.
- Sub-module alu_step_core is purely combinational. It produces the single-cycle op result and flags, and one shift/rotate step, at width N. seq_alu instantiates it and owns the FSM, counter, operand and result registers, and the flag register.

## Test plan
- Reset, then FunSel = 10100, A = 0x7FFF, B = 0x0001, WF = 1 -> OutValid 1 cycle after accept, ALUOut = 0x8000, FlagsOut = 4'b0011.
- Half-width ADD, A = 0x00FF, B = 0x0001 -> ALUOut = 0x0000, flags 4'b1100. Then ADC, A = 0x0001, B = 0x0001 -> ALUOut = 0x0003, C = 0.
- Full LSL, A = 0xA001, B = 0x0003 -> OutValid 4 cycles after accept, ALUOut = 0x0008, C = 1, N = 0, O held.
- OutReady low for 5 cycles in HOLD -> ALUOut and flags stable, InReady = 0. Next op with WF = 0 leaves FlagsOut unchanged.
- CSR with cnt = 0, A = 0x1234 -> ALUOut = 0x1234 after 1 cycle, C unchanged. LSR with cnt = 15 and Reset low on the 3rd EXEC cycle -> next edge: all outputs 0, no OutValid.
